// File: rtl/line_window_buffer.sv
// Multi-line delay buffer: emits a vertical column of LINES+1 pixels per accepted sample.
// Optional build macro LWB_BORDER_REPLICATE_EN: invalid taps replicate the nearest valid tap below.
module line_window_buffer #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 11,
  parameter int LINES  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ce,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  input  logic [ADDR_W:0]            h_size,
  output logic [WIDTH*(LINES+1)-1:0] taps,
  output logic [LINES:0]             tap_valid,
  output logic [ADDR_W-1:0]          col,
  output logic                       eol
);

  localparam int FW    = $clog2(LINES + 1);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] H_MIN = (ADDR_W+1)'(2);
  localparam logic [ADDR_W:0] H_MAX = (ADDR_W+1)'(DEPTH);

  logic [LINES:0][WIDTH-1:0]   taps_q, taps_d;
  logic [LINES:0]              tap_valid_q, tap_valid_d;
  logic [ADDR_W-1:0]           col_q, col_d;
  logic                        eol_q, eol_d;
  logic [ADDR_W-1:0]           ptr_q, ptr_d;
  logic [FW-1:0]               fill_q, fill_d;
  logic [ADDR_W:0]             h_size_q, h_size_d;

  logic                        accept;
  logic                        wrap;
  logic [ADDR_W:0]             h_eff;
  logic [LINES-1:0][WIDTH-1:0] rd_data;
  logic [LINES-1:0][WIDTH-1:0] wr_data;
  logic [LINES:0][WIDTH-1:0]   raw_tap;
  logic [LINES:0]              valid_now;
  logic [LINES:0][WIDTH-1:0]   sel_tap;

  assign accept = ce & ~rst & ~flush;
  assign wrap   = ({1'b0, ptr_q} == (h_size_q - 1'b1));

  // Read-first line memories sharing one pointer: line k is fed by line k-1's old value.
  for (genvar k = 0; k < LINES; k++) begin : g_line
    logic [WIDTH-1:0] mem [DEPTH];
    if (k == 0) begin : g_first
      assign wr_data[k] = din;
    end else begin : g_chain
      assign wr_data[k] = rd_data[k-1];
    end
    assign rd_data[k] = mem[ptr_q];
    always_ff @(posedge clk) begin
      if (accept) mem[ptr_q] <= wr_data[k];
    end
  end

  always_comb begin
    h_eff = h_size;
    if (h_size < H_MIN)      h_eff = H_MIN;
    else if (h_size > H_MAX) h_eff = H_MAX;
  end

  always_comb begin
    raw_tap[0]   = din;
    valid_now[0] = 1'b1;
    sel_tap[0]   = din;
    for (int k = 1; k <= LINES; k++) begin
      raw_tap[k]   = rd_data[k-1];
      valid_now[k] = (fill_q >= FW'(k));
`ifdef LWB_BORDER_REPLICATE_EN
      sel_tap[k]   = valid_now[k] ? raw_tap[k] : sel_tap[k-1];
`else
      sel_tap[k]   = valid_now[k] ? raw_tap[k] : '0;
`endif
    end
  end

  always_comb begin
    taps_d      = taps_q;
    tap_valid_d = tap_valid_q;
    col_d       = col_q;
    eol_d       = eol_q;
    ptr_d       = ptr_q;
    fill_d      = fill_q;
    h_size_d    = h_size_q;
    if (rst || flush) begin
      taps_d      = '0;
      tap_valid_d = '0;
      col_d       = '0;
      eol_d       = 1'b0;
      ptr_d       = '0;
      fill_d      = '0;
      h_size_d    = h_eff;
    end else if (ce) begin
      taps_d      = sel_tap;
      tap_valid_d = valid_now;
      col_d       = ptr_q;
      eol_d       = wrap;
      if (wrap) begin
        ptr_d    = '0;
        h_size_d = h_eff;
        // A new line length invalidates everything already stored in the delay lines.
        if (h_eff != h_size_q)         fill_d = '0;
        else if (fill_q < FW'(LINES))  fill_d = fill_q + 1'b1;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    taps_q      <= taps_d;
    tap_valid_q <= tap_valid_d;
    col_q       <= col_d;
    eol_q       <= eol_d;
    ptr_q       <= ptr_d;
    fill_q      <= fill_d;
    h_size_q    <= h_size_d;
  end

  assign taps      = taps_q;
  assign tap_valid = tap_valid_q;
  assign col       = col_q;
  assign eol       = eol_q;

endmodule

// File: tb/tb_line_window_buffer.sv
// Directed bench for line_window_buffer (LINES=2, ADDR_W=3 so the full-line case stays short).
module tb_line_window_buffer;

  localparam int WIDTH  = 16;
  localparam int ADDR_W = 3;
  localparam int LINES  = 2;
`ifdef LWB_BORDER_REPLICATE_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic                       clk = 1'b0;
  logic                       rst = 1'b0;
  logic                       ce = 1'b0;
  logic                       flush = 1'b0;
  logic [WIDTH-1:0]           din = '0;
  logic [ADDR_W:0]            h_size = '0;
  logic [WIDTH*(LINES+1)-1:0] taps;
  logic [LINES:0]             tap_valid;
  logic [ADDR_W-1:0]          col;
  logic                       eol;

  int n_checks = 0;
  int n_fail   = 0;

  line_window_buffer #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .LINES(LINES)) dut (
    .clk(clk), .rst(rst), .ce(ce), .flush(flush), .din(din), .h_size(h_size),
    .taps(taps), .tap_valid(tap_valid), .col(col), .eol(eol)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] pk(input int t2, input int t1, input int t0);
    return {16'(t2), 16'(t1), 16'(t0)};
  endfunction

  task automatic step(input logic c, input int d);
    ce  = c;
    din = 16'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int h);
    h_size = 4'(h);
    rst    = 1'b1;
    step(1'b1, 0);
    rst    = 1'b0;
  endtask

  logic [47:0] held;

  initial begin
    // reset state
    do_reset(4);
    check_eq("rst_taps", taps, 0);
    check_eq("rst_valid", tap_valid, 0);
    check_eq("rst_col", col, 0);
    check_eq("rst_eol", eol, 0);

    // ramp h=4, ce always high
    for (int n = 1; n <= 9; n++) begin
      step(1'b1, n);
      if (n == 5) check_eq("ramp5_taps", taps, pk(REP ? 1 : 0, 1, 5));
      if (n == 8) begin
        check_eq("ramp8_valid", tap_valid, 3'b011);
        check_eq("ramp8_col", col, 3);
        check_eq("ramp8_eol", eol, 1);
        check_eq("ramp8_taps", taps, pk(REP ? 4 : 0, 4, 8));
      end
      if (n == 9) begin
        check_eq("ramp9_taps", taps, pk(1, 5, 9));
        check_eq("ramp9_valid", tap_valid, 3'b111);
        check_eq("ramp9_col", col, 0);
        check_eq("ramp9_eol", eol, 0);
      end
    end

    // same ramp with ce gaps; junk din during gaps must be ignored
    do_reset(4);
    for (int n = 1; n <= 9; n++) begin
      step(1'b1, n);
      held = taps;
      step(1'b0, 1000 + n);
      step(1'b0, 2000 + n);
      check_eq("gap_hold", taps, held);
      if (n == 5) check_eq("gap5_taps", taps, pk(REP ? 1 : 0, 1, 5));
      if (n == 8) check_eq("gap8_col", col, 3);
    end
    check_eq("gap9_taps", taps, pk(1, 5, 9));
    check_eq("gap9_valid", tap_valid, 3'b111);

    // h_size changes to 6 during line 2
    do_reset(4);
    for (int n = 1; n <= 15; n++) begin
      if (n == 6) h_size = 4'd6;
      step(1'b1, n);
      if (n == 7) check_eq("hchg7_col", col, 2);
      if (n == 8) begin
        check_eq("hchg8_valid", tap_valid, 3'b011);
        check_eq("hchg8_eol", eol, 1);
        check_eq("hchg8_tap1", taps[31:16], 4);
      end
      if (n == 9) begin
        check_eq("hchg9_valid", tap_valid, 3'b001);
        check_eq("hchg9_col", col, 0);
      end
      if (n == 14) check_eq("hchg14_col", col, 5);
      if (n == 15) begin
        check_eq("hchg15_tap1", taps[31:16], 9);
        check_eq("hchg15_valid", tap_valid, 3'b011);
      end
    end

    // flush after 10 accepts
    do_reset(4);
    for (int n = 1; n <= 10; n++) step(1'b1, n);
    flush = 1'b1;
    step(1'b1, 55);
    flush = 1'b0;
    check_eq("flush_taps", taps, 0);
    check_eq("flush_valid", tap_valid, 0);
    check_eq("flush_col", col, 0);
    step(1'b1, 77);
    check_eq("flush_next_taps", taps, pk(REP ? 77 : 0, REP ? 77 : 0, 77));
    check_eq("flush_next_valid", tap_valid, 3'b001);

    // clamp low: h_size=0 behaves as 2
    do_reset(0);
    for (int n = 1; n <= 5; n++) begin
      step(1'b1, n);
      if (n == 4) begin
        check_eq("clamp0_col4", col, 1);
        check_eq("clamp0_eol4", eol, 1);
      end
    end
    check_eq("clamp0_taps", taps, pk(1, 3, 5));
    check_eq("clamp0_valid", tap_valid, 3'b111);

    // full line h=8 wraps at all ones
    do_reset(8);
    for (int n = 1; n <= 17; n++) begin
      step(1'b1, n);
      if (n == 8) begin
        check_eq("full8_col", col, 7);
        check_eq("full8_eol", eol, 1);
      end
      if (n == 9) check_eq("full9_tap1", taps[31:16], 1);
    end
    check_eq("full17_taps", taps, pk(1, 9, 17));
    check_eq("full17_col", col, 0);

    // clamp high: h_size=9 behaves as 8
    do_reset(9);
    for (int n = 1; n <= 9; n++) step(1'b1, n);
    check_eq("clamp9_tap1", taps[31:16], 1);
    check_eq("clamp9_valid", tap_valid, 3'b011);

    // rst has priority over flush and ce
    h_size = 4'd4;
    rst    = 1'b1;
    flush  = 1'b1;
    step(1'b1, 99);
    rst    = 1'b0;
    flush  = 1'b0;
    check_eq("prio_taps", taps, 0);
    check_eq("prio_valid", tap_valid, 0);
    check_eq("prio_col", col, 0);
    step(1'b1, 5);
    check_eq("prio_next_taps", taps, pk(REP ? 5 : 0, REP ? 5 : 0, 5));
    check_eq("prio_next_valid", tap_valid, 3'b001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
